// File: rtl/plotter_pkg.sv
// Shared types and constants for the pen plotter datapath.
// Coordinates are 9-bit; X=Y=511 marks the end of the drawing.
package plotter_pkg;

    localparam int COORD_W   = 9;
    localparam int X_MAX_DEF = 279;
    localparam int Y_MAX_DEF = 254;

    localparam logic [COORD_W-1:0] SENTINEL = 9'd511;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_POS = 3'd2,
        ST_PEN      = 3'd3,
        ST_CALC     = 3'd4,
        ST_STEP_HI  = 3'd5,
        ST_STEP_LO  = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                       input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Step pulse timer: one STEP_PERIOD-long frame per go, high for STEP_HIGH cycles
// on the axes enabled at go. A go on the last frame cycle starts the next frame seamlessly.
module step_pulse_gen #(
    parameter int STEP_PERIOD = 5000,
    parameter int STEP_HIGH   = 100
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic go,
    input  logic stepx_en,
    input  logic stepy_en,
    output logic oStepX,
    output logic oStepY,
    output logic last_high,
    output logic period_done
);

    localparam int               CNT_W    = $clog2(STEP_PERIOD + 1);
    localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(STEP_HIGH - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(STEP_PERIOD - 1);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             r_step_x;
    logic             r_step_y;

    assign last_high   = r_active && (r_cnt == HI_LAST);
    assign period_done = r_active && (r_cnt == PER_LAST);
    assign oStepX      = r_step_x;
    assign oStepY      = r_step_y;

    // Frame counter and registered step outputs.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_active <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
            r_step_x <= 1'b0;
            r_step_y <= 1'b0;
        end else if (go) begin
            r_active <= 1'b1;
            r_cnt    <= {CNT_W{1'b0}};
            r_step_x <= stepx_en;
            r_step_y <= stepy_en;
        end else if (r_active) begin
            if (period_done) begin
                r_active <= 1'b0;
                r_cnt    <= {CNT_W{1'b0}};
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (last_high) begin
                r_step_x <= 1'b0;
                r_step_y <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pos_to_stepper.sv
// Pulls pen targets from the upstream position stage and walks two stepper
// motors along a Bresenham line to each one, lifting/lowering the pen as asked.
module pos_to_stepper
    import plotter_pkg::*;
#(
    parameter int STEP_PERIOD = 5000,
    parameter int STEP_HIGH   = 100,
    parameter int PEN_WAIT    = 500000,
    parameter int X_MAX       = X_MAX_DEF,
    parameter int Y_MAX       = Y_MAX_DEF
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iStart,
    output logic               oPOS_REQUEST,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    input  logic               iDone,
    input  logic               iDown,
    output logic               oStepX,
    output logic               oDirX,
    output logic               oStepY,
    output logic               oDirY,
    output logic               oPen,
    output logic               oBusy,
    output logic               oFinish,
    output logic [COORD_W-1:0] oCurX,
    output logic [COORD_W-1:0] oCurY
);

    localparam int                 PEN_CW   = $clog2(PEN_WAIT + 1);
    localparam logic [PEN_CW-1:0]  PEN_LAST = PEN_CW'(PEN_WAIT - 1);
    localparam logic [COORD_W-1:0] X_LIM    = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_LIM    = COORD_W'(Y_MAX);

    state_t              r_state;
    logic                r_req;
    logic                r_pen;
    logic                r_busy;
    logic                r_finish;
    logic                r_dir_x;
    logic                r_dir_y;
    logic                r_go;
    logic [COORD_W-1:0]  r_cur_x;
    logic [COORD_W-1:0]  r_cur_y;
    logic [COORD_W-1:0]  r_tgt_x;
    logic [COORD_W-1:0]  r_tgt_y;
    logic [COORD_W-1:0]  r_dx;
    logic [COORD_W-1:0]  r_dy;
    logic signed [10:0]  r_err;
    logic [PEN_CW-1:0]   r_pen_cnt;

    logic                w_step_x;
    logic                w_step_y;
    logic                w_last_high;
    logic                w_period_done;
    logic                w_go;
    logic                w_en_x;
    logic                w_en_y;
    logic                w_at_tgt;
    logic [COORD_W-1:0]  w_calc_dx;
    logic [COORD_W-1:0]  w_calc_dy;
    logic signed [11:0]  w_e2;
    logic signed [11:0]  w_dx_s;
    logic signed [11:0]  w_dy_s;
    logic signed [10:0]  w_dx_e;
    logic signed [10:0]  w_dy_e;

    assign w_calc_dx = abs_diff(r_tgt_x, r_cur_x);
    assign w_calc_dy = abs_diff(r_tgt_y, r_cur_y);
    assign w_e2      = $signed({r_err, 1'b0});
    assign w_dx_s    = $signed({3'b000, r_dx});
    assign w_dy_s    = $signed({3'b000, r_dy});
    assign w_dx_e    = $signed({2'b00, r_dx});
    assign w_dy_e    = $signed({2'b00, r_dy});
    assign w_at_tgt  = (r_cur_x == r_tgt_x) && (r_cur_y == r_tgt_y);
    // Axis guards keep the walk from overshooting a target already reached on that axis.
    assign w_en_x    = (w_e2 > -w_dy_s) && (r_cur_x != r_tgt_x);
    assign w_en_y    = (w_e2 < w_dx_s) && (r_cur_y != r_tgt_y);
    // Back-to-back frames are launched on the final low cycle so the step rate is exact.
    assign w_go      = ((r_state == ST_STEP_HI) && r_go) ||
                       ((r_state == ST_STEP_LO) && w_period_done && iStart && !w_at_tgt);

    step_pulse_gen #(
        .STEP_PERIOD (STEP_PERIOD),
        .STEP_HIGH   (STEP_HIGH)
    ) u_pulse (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .go          (w_go),
        .stepx_en    (w_en_x),
        .stepy_en    (w_en_y),
        .oStepX      (w_step_x),
        .oStepY      (w_step_y),
        .last_high   (w_last_high),
        .period_done (w_period_done)
    );

    assign oPOS_REQUEST = r_req;
    assign oStepX       = w_step_x;
    assign oStepY       = w_step_y;
    assign oDirX        = r_dir_x;
    assign oDirY        = r_dir_y;
    assign oPen         = r_pen;
    assign oBusy        = r_busy;
    assign oFinish      = r_finish;
    assign oCurX        = r_cur_x;
    assign oCurY        = r_cur_y;

    // Main sequencer: handshake, pen control and Bresenham bookkeeping.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_pen     <= 1'b0;
            r_busy    <= 1'b0;
            r_finish  <= 1'b0;
            r_dir_x   <= 1'b0;
            r_dir_y   <= 1'b0;
            r_go      <= 1'b0;
            r_cur_x   <= {COORD_W{1'b0}};
            r_cur_y   <= {COORD_W{1'b0}};
            r_tgt_x   <= {COORD_W{1'b0}};
            r_tgt_y   <= {COORD_W{1'b0}};
            r_dx      <= {COORD_W{1'b0}};
            r_dy      <= {COORD_W{1'b0}};
            r_err     <= 11'sd0;
            r_pen_cnt <= {PEN_CW{1'b0}};
        end else begin
            r_req <= 1'b0;
            r_go  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (iStart) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!iStart) begin
                        r_state <= ST_IDLE;
                        r_pen   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_WAIT_POS;
                    end
                end
                ST_WAIT_POS: begin
                    if (!iStart) begin
                        r_state <= ST_IDLE;
                        r_pen   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (iDone) begin
                        if ((iX == SENTINEL) && (iY == SENTINEL)) begin
                            r_state  <= ST_DONE;
                            r_finish <= 1'b1;
                            r_pen    <= 1'b0;
                            r_busy   <= 1'b0;
                        end else begin
                            r_tgt_x <= clamp_coord(iX, X_LIM);
                            r_tgt_y <= clamp_coord(iY, Y_LIM);
                            if (iDown != r_pen) begin
                                r_pen     <= iDown;
                                r_pen_cnt <= {PEN_CW{1'b0}};
                                r_state   <= ST_PEN;
                            end else begin
                                r_state <= ST_CALC;
                            end
                        end
                    end
                end
                ST_PEN: begin
                    if (!iStart) begin
                        r_state <= ST_IDLE;
                        r_pen   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_pen_cnt == PEN_LAST) begin
                        r_state <= ST_CALC;
                    end else begin
                        r_pen_cnt <= r_pen_cnt + PEN_CW'(1);
                    end
                end
                ST_CALC: begin
                    if (!iStart) begin
                        r_state <= ST_IDLE;
                        r_pen   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dx    <= w_calc_dx;
                        r_dy    <= w_calc_dy;
                        r_err   <= $signed({2'b00, w_calc_dx}) - $signed({2'b00, w_calc_dy});
                        r_dir_x <= (r_tgt_x >= r_cur_x);
                        r_dir_y <= (r_tgt_y >= r_cur_y);
                        if (w_at_tgt) begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= ST_STEP_HI;
                            r_go    <= 1'b1;
                        end
                    end
                end
                ST_STEP_HI: begin
                    if (w_last_high) begin
                        if (w_step_x) begin
                            r_cur_x <= r_dir_x ? (r_cur_x + 9'd1) : (r_cur_x - 9'd1);
                        end
                        if (w_step_y) begin
                            r_cur_y <= r_dir_y ? (r_cur_y + 9'd1) : (r_cur_y - 9'd1);
                        end
                        r_err   <= r_err - (w_step_x ? w_dy_e : 11'sd0)
                                         + (w_step_y ? w_dx_e : 11'sd0);
                        r_state <= ST_STEP_LO;
                    end
                end
                ST_STEP_LO: begin
                    if (w_period_done) begin
                        if (!iStart) begin
                            r_state <= ST_IDLE;
                            r_pen   <= 1'b0;
                            r_busy  <= 1'b0;
                        end else if (w_at_tgt) begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= ST_STEP_HI;
                        end
                    end
                end
                ST_DONE: begin
                    r_pen <= 1'b0;
                    if (!iStart) begin
                        r_state  <= ST_IDLE;
                        r_finish <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_pen   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
